// File: rtl/sram_pkg.sv
// Shared types and constants for the clearable simple-dual-port node memory.
package sram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 18;
  localparam int unsigned DEF_DEPTH      = 32;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } sram_state_t;

  // Addresses at or beyond the populated depth never touch the array.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/sram_dp_clr_if.sv
// Access bus between the node-table controller / traversal pipeline and the memory.
interface sram_dp_clr_if
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  i_clear;
  logic                  i_we;
  logic [ADDR_WIDTH-1:0] i_waddr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH-1:0] i_wmask;
  logic                  i_re;
  logic [ADDR_WIDTH-1:0] i_raddr;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_rvalid;
  logic                  o_ready;

  modport master (
    output i_clear, i_we, i_waddr, i_wdata, i_wmask, i_re, i_raddr,
    input  o_rdata, o_rvalid, o_ready
  );

  modport slave (
    input  i_clear, i_we, i_waddr, i_wdata, i_wmask, i_re, i_raddr,
    output o_rdata, o_rvalid, o_ready
  );

endinterface

// File: rtl/sram_dp_array.sv
// Plain storage: one masked synchronous write port, one registered read port
// returning the merged word when reading the address being written.
module sram_dp_array
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_wmask,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] merged;

  assign merged = (mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);

  // NOTE: no reset on storage or its read register; the clear engine and the
  // top-level output gating give defined contents and outputs instead.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= merged;
    end
    if (i_re) begin
      if (i_we && (i_waddr == i_raddr)) begin
        o_rdata <= merged;
      end else begin
        o_rdata <= mem[i_raddr];
      end
    end
  end

endmodule

// File: rtl/sram_dp_clr.sv
// Clearable simple-dual-port node memory: clear FSM and counter, write-port
// arbitration between clear engine and user, range checks, read-valid pipeline.
module sram_dp_clr
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sram_dp_clr_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  sram_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q;
  logic                  rvalid_q;
  logic                  rzero_q;

  logic                  clearing;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  rd_fire;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_wmask;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign clearing    = (state_q == S_CLEAR);
  assign wr_in_range = in_range(32'(bus.i_waddr), DEPTH);
  assign rd_in_range = in_range(32'(bus.i_raddr), DEPTH);
  // ready_q is never set while clearing, so it alone gates user accesses.
  assign rd_fire     = ready_q & bus.i_re;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        if (bus.i_clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.i_clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rzero_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Ready rises one cycle after the last clear write and drops on the
      // edge that samples a clear request.
      ready_q  <= (state_q == S_IDLE) && (state_d == S_IDLE);
      rvalid_q <= rd_fire;
      if (rd_fire) begin
        rzero_q <= ~rd_in_range;
      end
    end
  end

  always_comb begin
    arr_we    = ready_q & bus.i_we & wr_in_range;
    arr_waddr = bus.i_waddr;
    arr_wdata = bus.i_wdata;
    arr_wmask = bus.i_wmask;
    if (clearing) begin
      arr_we    = 1'b1;
      arr_waddr = cnt_q;
      arr_wdata = '0;
      arr_wmask = '1;
    end
  end

  assign arr_re = rd_fire & rd_in_range;

  sram_dp_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (arr_we),
    .i_waddr (arr_waddr),
    .i_wdata (arr_wdata),
    .i_wmask (arr_wmask),
    .i_re    (arr_re),
    .i_raddr (bus.i_raddr),
    .o_rdata (arr_rdata)
  );

  // rzero_q covers both reset and out-of-range reads, hiding the unreset array register.
  assign bus.o_rdata  = rzero_q ? '0 : arr_rdata;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_ready  = ready_q;

endmodule

// File: tb/tb_sram_dp_clr.sv
// Directed bench for sram_dp_clr: a 32-deep and a 20-deep instance, reads scored
// against a queue of expected words filled when each read is issued.
module tb_sram_dp_clr;
  import sram_pkg::*;

  localparam int AW = 5;
  localparam int DW = 18;

  typedef struct {
    logic [DW-1:0] data;
    string         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_dp_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  sram_dp_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  sram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(32)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  sram_dp_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(20)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] mdl_a [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobes_off();
    bus_a.i_we = 1'b0; bus_a.i_re = 1'b0; bus_a.i_clear = 1'b0;
    bus_b.i_we = 1'b0; bus_b.i_re = 1'b0; bus_b.i_clear = 1'b0;
  endtask

  // One clock: sample after the edge, score any completed reads, drop strobes.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check({"A rvalid ", e.tag}, 32'(bus_a.o_rvalid), 32'd1);
      check({"A rdata ", e.tag}, 32'(bus_a.o_rdata), 32'(e.data));
    end else begin
      check("A no rvalid", 32'(bus_a.o_rvalid), 32'd0);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check({"B rvalid ", e.tag}, 32'(bus_b.o_rvalid), 32'd1);
      check({"B rdata ", e.tag}, 32'(bus_b.o_rdata), 32'(e.data));
    end else begin
      check("B no rvalid", 32'(bus_b.o_rvalid), 32'd0);
    end
    strobes_off();
  endtask

  task automatic wr_a(input int addr, input logic [DW-1:0] data, input logic [DW-1:0] mask);
    bus_a.i_we    = 1'b1;
    bus_a.i_waddr = AW'(addr);
    bus_a.i_wdata = data;
    bus_a.i_wmask = mask;
    mdl_a[addr]   = (mdl_a[addr] & ~mask) | (data & mask);
  endtask

  task automatic rd_a(input int addr);
    exp_t e;
    bus_a.i_re    = 1'b1;
    bus_a.i_raddr = AW'(addr);
    e.data = mdl_a[addr];
    e.tag  = $sformatf("rd%0d", addr);
    q_a.push_back(e);
  endtask

  task automatic rd_b(input int addr, input logic [DW-1:0] exp);
    exp_t e;
    bus_b.i_re    = 1'b1;
    bus_b.i_raddr = AW'(addr);
    e.data = exp;
    e.tag  = $sformatf("rd%0d", addr);
    q_b.push_back(e);
  endtask

  task automatic wr_b(input int addr, input logic [DW-1:0] data, input logic [DW-1:0] mask);
    bus_b.i_we    = 1'b1;
    bus_b.i_waddr = AW'(addr);
    bus_b.i_wdata = data;
    bus_b.i_wmask = mask;
  endtask

  // Ready timeline after a reset release: A after 33 edges, B after 21.
  task automatic ready_after_reset();
    for (int i = 1; i <= 33; i++) begin
      step();
      check($sformatf("A ready edge %0d", i), 32'(bus_a.o_ready), 32'(i >= 33));
      check($sformatf("B ready edge %0d", i), 32'(bus_b.o_ready), 32'(i >= 21));
    end
    for (int a = 0; a < 32; a++) mdl_a[a] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    strobes_off();
    bus_a.i_waddr = '0; bus_a.i_wdata = '0; bus_a.i_wmask = '0; bus_a.i_raddr = '0;
    bus_b.i_waddr = '0; bus_b.i_wdata = '0; bus_b.i_wmask = '0; bus_b.i_raddr = '0;
    for (int a = 0; a < 32; a++) mdl_a[a] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("A reset ready",  32'(bus_a.o_ready),  32'd0);
    check("A reset rvalid", 32'(bus_a.o_rvalid), 32'd0);
    check("A reset rdata",  32'(bus_a.o_rdata),  32'd0);
    check("B reset ready",  32'(bus_b.o_ready),  32'd0);
    check("B reset rvalid", 32'(bus_b.o_rvalid), 32'd0);
    check("B reset rdata",  32'(bus_b.o_rdata),  32'd0);
    rst_n = 1'b1;
    ready_after_reset();

    // Whole array reads zero after the power-on clear
    for (int a = 0; a < 32; a++) begin
      rd_a(a);
      step();
    end

    // Masked write merge
    wr_a(1, 18'h3_0201, 18'h3_FFFF); step();
    wr_a(1, 18'h0_00FF, 18'h0_000F); step();
    check("A model merge", 32'(mdl_a[1]), 32'h3_020F);
    rd_a(1); step();

    // Read-during-write, full and partial mask
    wr_a(5, 18'h2_0003, 18'h3_FFFF); rd_a(5); step();
    wr_a(1, 18'h0_0030, 18'h0_00F0); rd_a(1); step();

    // Independent write and read in one cycle
    wr_a(2, 18'h0_1111, 18'h3_FFFF); rd_a(1); step();
    rd_a(2); step();

    // Out-of-range on the 20-deep instance, plus its last valid word
    wr_b(25, 18'h3_FFFF, 18'h3_FFFF); step();
    rd_b(25, 18'h0_0000); step();
    rd_b(5, 18'h0_0000); step();
    wr_b(19, 18'h1_2345, 18'h3_FFFF); step();
    rd_b(19, 18'h1_2345); step();

    // Fill 0..7, then clear with a same-cycle read and write still performed
    for (int a = 0; a < 8; a++) begin
      wr_a(a, DW'((a + 1) * 'h111), 18'h3_FFFF);
      step();
    end
    rd_a(7); step();
    bus_a.i_clear = 1'b1;
    rd_a(3);
    wr_a(8, 18'h3_0000, 18'h3_FFFF);
    step();
    check("A ready after clear edge", 32'(bus_a.o_ready), 32'd0);
    for (int a = 0; a < 32; a++) mdl_a[a] = '0;
    for (int i = 1; i <= 33; i++) begin
      bus_a.i_re    = 1'b1;
      bus_a.i_raddr = AW'(i % 8);
      step();
      check($sformatf("A clear ready edge %0d", i), 32'(bus_a.o_ready), 32'(i >= 33));
    end
    for (int a = 0; a < 32; a++) begin
      rd_a(a);
      step();
    end

    // Reset during clear and during a completing read
    wr_a(4, 18'h2_AAAA, 18'h3_FFFF); step();
    rd_a(4); step();
    bus_a.i_clear = 1'b1;
    step();
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) rd_b(19, 18'h1_2345);
      step();
    end
    check("A rdata held in clear", 32'(bus_a.o_rdata), 32'h2_AAAA);
    rst_n = 1'b0;
    #1;
    check("A midclear rst ready",  32'(bus_a.o_ready),  32'd0);
    check("A midclear rst rvalid", 32'(bus_a.o_rvalid), 32'd0);
    check("A midclear rst rdata",  32'(bus_a.o_rdata),  32'd0);
    check("B midread rst ready",   32'(bus_b.o_ready),  32'd0);
    check("B midread rst rvalid",  32'(bus_b.o_rvalid), 32'd0);
    check("B midread rst rdata",   32'(bus_b.o_rdata),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_after_reset();
    rd_a(4); rd_b(19, 18'h0_0000); step();
    rd_a(31); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
